// File: rtl/mult_add_seq_4bit.sv
// Sequential shift-and-add multiply-accumulate: result = a*b + c.
// One operand bit is consumed per cycle, so latency is fixed at WIDTH
// iterations after the accepting edge regardless of operand values.
module mult_add_seq_4bit #(
   parameter int WIDTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic [WIDTH-1:0]   c_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] result_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] sum;

   // Partial-product add for the current multiplier LSB.
   assign sum = acc_q + (b_q[0] ? a_q : '0);

   // Next-state logic: accept in IDLE, iterate in RUN, publish on last step.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d     = {{WIDTH{1'b0}}, a_i};
               b_d     = b_i;
               acc_d   = {{WIDTH{1'b0}}, c_i};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            // The final iteration's sum goes straight to result so done
            // and result appear on the same edge.
            if (cnt_q == CW'(WIDTH - 1)) begin
               result_d = sum;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign busy_o   = (state_q == RUN);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mult_add_seq_4bit.sv
// Directed bench for mult_add_seq_4bit: vector table plus handshake,
// reset-abort, back-to-back and divider-inverse sequences.
module tb_mult_add_seq_4bit;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic [3:0] a_i, b_i, c_i;
   logic       busy_o, done_o;
   logic [7:0] result_o;

   int checks = 0;
   int errors = 0;

   mult_add_seq_4bit #(.WIDTH(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .a_i(a_i), .b_i(b_i), .c_i(c_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int a;
      int b;
      int c;
      int exp;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Launch one operation and check latency, busy length, result and
   // that done drops after one cycle.
   task automatic run_op(input int a, input int b, input int c, input int exp,
                         input string name);
      int k;
      int bc;
      @(negedge clk_i);
      start_i = 1'b1;
      a_i = 4'(a); b_i = 4'(b); c_i = 4'(c);
      @(negedge clk_i);           // accepting edge E0 has passed
      start_i = 1'b0;
      a_i = 4'hx; b_i = 4'hx; c_i = 4'hx;
      k = 0; bc = 0;
      while (!done_o && k < 20) begin
         if (busy_o) bc++;
         @(negedge clk_i);
         k++;
      end
      chk({name, " latency"}, k, 4);
      chk({name, " busy_cycles"}, bc, 4);
      chk({name, " busy_at_done"}, int'(busy_o), 0);
      chk({name, " result"}, int'(result_o), exp);
      @(negedge clk_i);
      chk({name, " done_pulse_width"}, int'(done_o), 0);
      chk({name, " result_held"}, int'(result_o), exp);
   endtask

   initial begin
      vec_t vt[6];
      int k;
      int ndone;
      int d0, d1, r0, r1;

      vt[0] = '{3, 5, 2, 17};
      vt[1] = '{15, 15, 15, 240};
      vt[2] = '{0, 9, 7, 7};
      vt[3] = '{7, 0, 5, 5};
      vt[4] = '{1, 1, 0, 1};
      vt[5] = '{15, 1, 0, 15};

      rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; c_i = '0;
      repeat (2) @(negedge clk_i);
      chk("reset busy", int'(busy_o), 0);
      chk("reset done", int'(done_o), 0);
      chk("reset result", int'(result_o), 0);
      rst_i = 1'b0;

      for (int i = 0; i < 6; i++)
         run_op(vt[i].a, vt[i].b, vt[i].c, vt[i].exp, $sformatf("vec%0d", i));

      // Start while busy is ignored.
      @(negedge clk_i);
      start_i = 1'b1; a_i = 4'd6; b_i = 4'd7; c_i = 4'd1;
      @(negedge clk_i);           // E0
      start_i = 1'b0;
      @(negedge clk_i);           // E1
      start_i = 1'b1; a_i = 4'd1; b_i = 4'd1; c_i = 4'd1;
      @(negedge clk_i);           // E2
      start_i = 1'b0;
      ndone = 0; d0 = -1; r0 = 0;
      for (k = 2; k < 14; k++) begin
         if (done_o) begin
            ndone++;
            if (d0 < 0) begin d0 = k; r0 = int'(result_o); end
         end
         @(negedge clk_i);
      end
      chk("ignore done_count", ndone, 1);
      chk("ignore done_time", d0, 4);
      chk("ignore result", r0, 43);

      // Async reset mid-RUN aborts without done.
      @(negedge clk_i);
      start_i = 1'b1; a_i = 4'd9; b_i = 4'd9; c_i = 4'd0;
      @(negedge clk_i);           // E0
      start_i = 1'b0;
      @(negedge clk_i);           // E1
      #2 rst_i = 1'b1;
      #1;
      chk("abort busy", int'(busy_o), 0);
      chk("abort result", int'(result_o), 0);
      chk("abort done", int'(done_o), 0);
      rst_i = 1'b0;
      ndone = 0;
      repeat (8) begin
         @(negedge clk_i);
         if (done_o) ndone++;
      end
      chk("abort no_done", ndone, 0);
      run_op(2, 2, 0, 4, "post_abort");

      // Back-to-back with start held high.
      @(negedge clk_i);
      start_i = 1'b1; a_i = 4'd1; b_i = 4'd2; c_i = 4'd3;
      @(negedge clk_i);           // E0
      a_i = 4'd4; b_i = 4'd4; c_i = 4'd4;
      d0 = -1; d1 = -1; r0 = 0; r1 = 0; ndone = 0;
      for (k = 0; k < 15; k++) begin
         if (done_o) begin
            ndone++;
            if (d0 < 0) begin d0 = k; r0 = int'(result_o); end
            else if (d1 < 0) begin d1 = k; r1 = int'(result_o); end
         end
         if (k == 5) start_i = 1'b0;
         @(negedge clk_i);
      end
      chk("b2b done_count", ndone, 2);
      chk("b2b first_time", d0, 4);
      chk("b2b spacing", d1 - d0, 5);
      chk("b2b first_result", r0, 5);
      chk("b2b second_result", r1, 20);

      // Rebuild every dividend from the divider's quotient and remainder.
      for (int dv = 0; dv < 16; dv++)
         for (int ds = 1; ds < 16; ds++)
            run_op(dv / ds, ds, dv % ds, dv, $sformatf("inv_%0d_%0d", dv, ds));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
